// File: rtl/fio_tm_pkg.sv
// Shared definitions for the FileIO -> TaskManager task-list link.
// A task record packs, MSB first:
//   [28] valid, [27:20] SW warp ID, [19:11] PC, [10:3] active mask,
//   [2:0] register pairs.
// The package also holds the default list capacity and the loader state
// encoding.
package fio_tm_pkg;

    localparam int TASK_W    = 29;

    localparam int VALID_BIT = 28;
    localparam int SWID_LSB  = 20;
    localparam int SWID_W    = 8;
    localparam int PC_LSB    = 11;
    localparam int PC_W      = 9;
    localparam int AM_LSB    = 3;
    localparam int AM_W      = 8;
    localparam int NREG_LSB  = 0;
    localparam int NREG_W    = 3;

    // TaskManager task-list capacity.
    localparam int MAX_TASKS = 256;

    // Wide enough to hold MAX_TASKS itself, not only MAX_TASKS-1.
    localparam int COUNT_W   = 9;

    typedef enum logic [2:0] {
        ST_LOAD   = 3'd0,
        ST_WRLAST = 3'd1,
        ST_START  = 3'd2,
        ST_RUN    = 3'd3,
        ST_CLEAR  = 3'd4,
        ST_HOLD   = 3'd5
    } loader_state_e;

    // A record may only be written into the TaskManager if its valid bit is set.
    function automatic logic rec_is_valid(input logic [TASK_W-1:0] rec);
        return rec[VALID_BIT];
    endfunction

endpackage

// File: rtl/task_list_loader_sat_counter.sv
// Saturating up-counter.
// Ports:
//   clk, rst : clock, synchronous active-low reset (clears the count)
//   clr      : synchronous clear; has priority over en
//   en       : count up by one, holding at all-ones
//   q        : current count (registered)
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (en && (q_q != {W{1'b1}})) begin
            q_d = q_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/task_list_loader.sv
// Host-side loader for the FileIO -> TaskManager task list.
// Accepts task records from a valid/ready host stream, drops records that
// are marked invalid or that exceed the list capacity, writes the rest into
// the TaskManager, starts it after the last record, times the run, then
// clears it and re-arms for the next batch.
//
// Host handshake: a record is transferred on a rising clk edge where
// host_valid and host_ready are both 1; host_ready depends only on the
// state register, and host_valid is don't-care while host_ready is 0.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   host_valid/ready    record stream handshake
//   host_data, host_last record and end-of-batch marker
//   Wen_FIO_TM, Din_FIO_TM  task write strobe and data (registered)
//   start_FIO_TM        one-cycle start pulse (registered)
//   clear_FIO_TM        one-cycle clear pulse (registered)
//   finished_TM_FIO     TaskManager finished level, looked at only in RUN
//   busy                high whenever not accepting records
//   done                one-cycle pulse together with the clear
//   task_count          records forwarded in the current/last batch
//   run_cycles          RUN cycles of the last batch, saturating
//   err_invalid         sticky: a record with valid bit 0 was dropped
//   err_overflow        sticky: a record beyond capacity was dropped
module task_list_loader #(
    parameter int MAX_TASKS = fio_tm_pkg::MAX_TASKS,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             host_valid,
    output logic             host_ready,
    input  logic [28:0]      host_data,
    input  logic             host_last,
    output logic             Wen_FIO_TM,
    output logic [28:0]      Din_FIO_TM,
    output logic             start_FIO_TM,
    output logic             clear_FIO_TM,
    input  logic             finished_TM_FIO,
    output logic             busy,
    output logic             done,
    output logic [8:0]       task_count,
    output logic [CNT_W-1:0] run_cycles,
    output logic             err_invalid,
    output logic             err_overflow
);

    import fio_tm_pkg::*;

    loader_state_e        state_q, state_d;
    logic                 wen_q, wen_d;
    logic [TASK_W-1:0]    din_q, din_d;
    logic                 start_q, start_d;
    logic                 clear_q, clear_d;
    logic                 done_q, done_d;
    logic [COUNT_W-1:0]   task_count_q, task_count_d;
    logic                 err_invalid_q, err_invalid_d;
    logic                 err_overflow_q, err_overflow_d;
    // Set when a batch completes; the next accepted record starts a new
    // batch and wipes the count and error flags of the previous one.
    logic                 fresh_q, fresh_d;

    logic                 handshake;
    logic [COUNT_W-1:0]   count_base;
    logic                 err_invalid_base;
    logic                 err_overflow_base;
    logic                 run_clr;
    logic                 run_en;

    assign host_ready = (state_q == ST_LOAD);
    assign busy       = (state_q != ST_LOAD);
    assign handshake  = host_valid && host_ready;

    // Counter sources for the current record: a fresh batch starts from zero.
    assign count_base        = fresh_q ? '0   : task_count_q;
    assign err_invalid_base  = fresh_q ? 1'b0 : err_invalid_q;
    assign err_overflow_base = fresh_q ? 1'b0 : err_overflow_q;

    // run_cycles is zeroed in START and counts every RUN cycle except the
    // one in which finished is seen.
    assign run_clr = (state_q == ST_START);
    assign run_en  = (state_q == ST_RUN) && !finished_TM_FIO;

    always_comb begin
        state_d        = state_q;
        wen_d          = 1'b0;
        din_d          = din_q;
        start_d        = 1'b0;
        clear_d        = 1'b0;
        done_d         = 1'b0;
        task_count_d   = task_count_q;
        err_invalid_d  = err_invalid_q;
        err_overflow_d = err_overflow_q;
        fresh_d        = fresh_q;

        case (state_q)
            ST_LOAD: begin
                if (handshake) begin
                    fresh_d        = 1'b0;
                    task_count_d   = count_base;
                    err_invalid_d  = err_invalid_base;
                    err_overflow_d = err_overflow_base;
                    if (!rec_is_valid(host_data)) begin
                        err_invalid_d = 1'b1;
                    end else if (32'(count_base) < 32'(MAX_TASKS)) begin
                        wen_d        = 1'b1;
                        din_d        = host_data;
                        task_count_d = count_base + 9'd1;
                    end else begin
                        err_overflow_d = 1'b1;
                    end
                    if (host_last) begin
                        state_d = ST_WRLAST;
                    end
                end
            end
            ST_WRLAST: begin
                // Last write is on the bus now; start goes out next cycle.
                start_d = 1'b1;
                state_d = ST_START;
            end
            ST_START: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (finished_TM_FIO) begin
                    clear_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                fresh_d = 1'b1;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                // TaskManager is in its clear state and would ignore writes.
                state_d = ST_LOAD;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= ST_LOAD;
            wen_q          <= 1'b0;
            din_q          <= '0;
            start_q        <= 1'b0;
            clear_q        <= 1'b0;
            done_q         <= 1'b0;
            task_count_q   <= '0;
            err_invalid_q  <= 1'b0;
            err_overflow_q <= 1'b0;
            fresh_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            wen_q          <= wen_d;
            din_q          <= din_d;
            start_q        <= start_d;
            clear_q        <= clear_d;
            done_q         <= done_d;
            task_count_q   <= task_count_d;
            err_invalid_q  <= err_invalid_d;
            err_overflow_q <= err_overflow_d;
            fresh_q        <= fresh_d;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_run_counter (
        .clk (clk),
        .rst (rst),
        .clr (run_clr),
        .en  (run_en),
        .q   (run_cycles)
    );

    assign Wen_FIO_TM   = wen_q;
    assign Din_FIO_TM   = din_q;
    assign start_FIO_TM = start_q;
    assign clear_FIO_TM = clear_q;
    assign done         = done_q;
    assign task_count   = task_count_q;
    assign err_invalid  = err_invalid_q;
    assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_task_list_loader.sv
// Bench for task_list_loader. A transaction-level model schedules, per
// cycle, what every output must be (writes one cycle after each accepted
// record, start two cycles after the last record, clear/done the cycle after
// finished, ready again three cycles after finished); one compare process
// checks the DUT against that schedule on every cycle.
module tb_task_list_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        host_valid = 1'b0;
  logic        host_ready;
  logic [28:0] host_data = '0;
  logic        host_last = 1'b0;
  logic        wen;
  logic [28:0] din;
  logic        start;
  logic        clr;
  logic        fin = 1'b0;
  logic        busy;
  logic        done;
  logic [8:0]  task_count;
  logic [31:0] run_cycles;
  logic        err_invalid;
  logic        err_overflow;

  task_list_loader #(.MAX_TASKS(256), .CNT_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .host_valid      (host_valid),
    .host_ready      (host_ready),
    .host_data       (host_data),
    .host_last       (host_last),
    .Wen_FIO_TM      (wen),
    .Din_FIO_TM      (din),
    .start_FIO_TM    (start),
    .clear_FIO_TM    (clr),
    .finished_TM_FIO (fin),
    .busy            (busy),
    .done            (done),
    .task_count      (task_count),
    .run_cycles      (run_cycles),
    .err_invalid     (err_invalid),
    .err_overflow    (err_overflow)
  );

  // clock / cycle counter: cycle k runs from posedge k to posedge k+1
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // scoreboard
  int total = 0;
  int bad = 0;
  logic [28:0] exp_q[$];        // records expected on the write bus, in order
  logic [28:0] exp_wen[int];    // cycle -> data expected on the write bus
  bit          start_at[int];
  bit          clear_at[int];
  logic [8:0]  sch_cnt[int];
  logic        sch_ei[int];
  logic        sch_eo[int];
  logic [31:0] sch_run[int];
  int          busy_lo = 0;
  int          busy_hi = 0;
  logic [8:0]  cur_cnt = '0;
  logic        cur_ei = 1'b0;
  logic        cur_eo = 1'b0;
  logic [31:0] cur_run = '0;

  // model of the batch rules
  int   m_cnt = 0;
  logic m_ei = 1'b0;
  logic m_eo = 1'b0;
  bit   m_fresh = 1'b1;

  int wen_seen = 0;
  int done_seen = 0;
  int start_seen_cyc = -1;
  int last_hs = 0;

  logic [28:0] recs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [28:0] mk(input bit v, input logic [7:0] sw, input logic [8:0] pc,
                                     input logic [7:0] am, input logic [2:0] nr);
    return {v, sw, pc, am, nr};
  endfunction

  task automatic model_hs(input int c, input logic [28:0] d);
    if (m_fresh) begin
      m_cnt = 0;
      m_ei = 1'b0;
      m_eo = 1'b0;
      m_fresh = 1'b0;
    end
    if (!d[28]) m_ei = 1'b1;
    else if (m_cnt < 256) begin
      exp_wen[c + 1] = d;
      exp_q.push_back(d);
      m_cnt++;
    end else m_eo = 1'b1;
    sch_cnt[c + 1] = 9'(m_cnt);
    sch_ei[c + 1] = m_ei;
    sch_eo[c + 1] = m_eo;
  endtask

  task automatic model_reset(input int r);
    for (int k = r + 1; k < r + 700; k++) begin
      if (exp_wen.exists(k)) exp_wen.delete(k);
      if (start_at.exists(k)) start_at.delete(k);
      if (clear_at.exists(k)) clear_at.delete(k);
      if (sch_cnt.exists(k)) sch_cnt.delete(k);
      if (sch_ei.exists(k)) sch_ei.delete(k);
      if (sch_eo.exists(k)) sch_eo.delete(k);
      if (sch_run.exists(k)) sch_run.delete(k);
    end
    busy_hi = r + 1;
    sch_cnt[r + 1] = '0;
    sch_ei[r + 1] = 1'b0;
    sch_eo[r + 1] = 1'b0;
    sch_run[r + 1] = '0;
    m_cnt = 0;
    m_ei = 1'b0;
    m_eo = 1'b0;
    m_fresh = 1'b1;
  endtask

  // compare process
  always @(negedge clk) begin
    if (cyc >= 1) begin
      logic exp_ready;
      if (sch_cnt.exists(cyc)) cur_cnt = sch_cnt[cyc];
      if (sch_ei.exists(cyc)) cur_ei = sch_ei[cyc];
      if (sch_eo.exists(cyc)) cur_eo = sch_eo[cyc];
      if (sch_run.exists(cyc)) cur_run = sch_run[cyc];
      exp_ready = !(cyc >= busy_lo && cyc < busy_hi);
      chk("host_ready", host_ready, exp_ready);
      chk("busy", busy, !exp_ready);
      chk("wen", wen, exp_wen.exists(cyc) ? 1 : 0);
      if (exp_wen.exists(cyc)) begin
        chk("din", din, exp_wen[cyc]);
        if (exp_q.size() > 0) chk("din_order", din, exp_q.pop_front());
      end
      chk("start", start, start_at.exists(cyc) ? 1 : 0);
      chk("clear", clr, clear_at.exists(cyc) ? 1 : 0);
      chk("done", done, clear_at.exists(cyc) ? 1 : 0);
      chk("task_count", task_count, cur_cnt);
      chk("err_invalid", err_invalid, cur_ei);
      chk("err_overflow", err_overflow, cur_eo);
      chk("run_cycles", run_cycles, cur_run);
      chk("wen_start_clear_excl", (int'(wen === 1'b1) + int'(start === 1'b1) + int'(clr === 1'b1)) > 1, 0);
      if (wen === 1'b1) chk("wen_din_valid", din[28], 1);
      if (wen === 1'b1) wen_seen++;
      if (done === 1'b1) done_seen++;
      if (start === 1'b1) start_seen_cyc = cyc;
    end
  end

  // driver: one batch from recs, TaskManager finishing d RUN cycles in
  task automatic run_batch(input int d, input bit hold_v, input int rst_after);
    int c, s, f, n;
    n = recs.size();
    wen_seen = 0;
    done_seen = 0;
    c = cyc;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      host_valid = 1'b1;
      host_data = recs[i];
      host_last = (i == n - 1);
      c = cyc;
      model_hs(c, recs[i]);
    end
    last_hs = c;
    busy_lo = c + 1;
    s = c + 2;
    f = s + 1 + d;
    busy_hi = f + 3;
    start_at[s] = 1'b1;
    clear_at[f + 1] = 1'b1;
    for (int k = s + 1; k <= f; k++) sch_run[k] = 32'(k - s - 1);
    m_fresh = 1'b1;
    @(posedge clk); #1;
    host_last = 1'b0;
    host_valid = hold_v;
    host_data = mk(1'b1, 8'hEE, 9'h1FF, 8'hFF, 3'd7);
    while (cyc < f + 3) begin
      if (rst_after >= 0 && cyc == s + 1 + rst_after) begin
        rst = 1'b0;
        fin = 1'b0;
        host_valid = 1'b0;
        model_reset(cyc);
        @(posedge clk); #1;
        rst = 1'b1;
        return;
      end
      fin = (cyc >= f && cyc <= f + 2);
      @(posedge clk); #1;
    end
    host_valid = 1'b0;
    fin = 1'b0;
  endtask

  initial begin
    // reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", host_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_run_cycles", run_cycles, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // batch 1: three valid records, 10 RUN cycles
    recs = {};
    recs.push_back(mk(1'b1, 8'h01, 9'h010, 8'hFF, 3'd1));
    recs.push_back(mk(1'b1, 8'h02, 9'h020, 8'h0F, 3'd2));
    recs.push_back(mk(1'b1, 8'h03, 9'h030, 8'hF0, 3'd3));
    run_batch(10, 1'b0, -1);
    chk("b1_wen_count", wen_seen, 3);
    chk("b1_task_count", task_count, 3);
    chk("b1_run_cycles", run_cycles, 10);
    chk("b1_start_latency", start_seen_cyc - last_hs, 2);
    chk("b1_done_count", done_seen, 1);

    // batch 2: valid, invalid, valid
    recs = {};
    recs.push_back(mk(1'b1, 8'h10, 9'h100, 8'h01, 3'd0));
    recs.push_back(mk(1'b0, 8'h11, 9'h101, 8'h02, 3'd1));
    recs.push_back(mk(1'b1, 8'h12, 9'h102, 8'h04, 3'd2));
    run_batch(3, 1'b0, -1);
    chk("b2_wen_count", wen_seen, 2);
    chk("b2_err_invalid", err_invalid, 1);
    chk("b2_err_overflow", err_overflow, 0);
    chk("b2_task_count", task_count, 2);
    chk("b2_run_cycles", run_cycles, 3);

    // batch 3: 258 valid records, two overflow
    recs = {};
    for (int i = 0; i < 258; i++) recs.push_back(mk(1'b1, 8'(i), 9'(i * 3), 8'(i ^ 8'h5A), 3'(i)));
    run_batch(2, 1'b0, -1);
    chk("b3_wen_count", wen_seen, 256);
    chk("b3_err_overflow", err_overflow, 1);
    chk("b3_err_invalid_cleared", err_invalid, 0);
    chk("b3_task_count", task_count, 256);
    chk("b3_done_count", done_seen, 1);

    // batch 4: single invalid record, valid held high while busy
    recs = {};
    recs.push_back(mk(1'b0, 8'hAA, 9'h0AA, 8'hAA, 3'd5));
    run_batch(0, 1'b1, -1);
    chk("b4_wen_count", wen_seen, 0);
    chk("b4_done_count", done_seen, 1);
    chk("b4_task_count", task_count, 0);
    chk("b4_err_invalid", err_invalid, 1);
    chk("b4_run_cycles", run_cycles, 0);

    // batch 5: reset during RUN
    recs = {};
    recs.push_back(mk(1'b1, 8'h21, 9'h021, 8'h21, 3'd1));
    recs.push_back(mk(1'b1, 8'h22, 9'h022, 8'h22, 3'd2));
    run_batch(30, 1'b1, 5);
    chk("b5_rst_ready", host_ready, 1);
    chk("b5_rst_task_count", task_count, 0);
    chk("b5_rst_run_cycles", run_cycles, 0);
    chk("b5_rst_done_count", done_seen, 0);

    // batch 6: recovery after reset
    recs = {};
    recs.push_back(mk(1'b1, 8'h31, 9'h131, 8'h31, 3'd4));
    run_batch(4, 1'b0, -1);
    chk("b6_task_count", task_count, 1);
    chk("b6_run_cycles", run_cycles, 4);
    chk("b6_wen_count", wen_seen, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("exp_q_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/task_list_loader.md
# task_list_loader

Host-side transmitter for the FileIO→TaskManager task-list protocol. Accepts 29-bit task records from a host stream (valid/ready), screens and counts them, writes them into the TaskManager with `Wen_FIO_TM`/`Din_FIO_TM`, then issues `start_FIO_TM` after the last record. It waits for `finished_TM_FIO`, measures run time, issues `clear_FIO_TM`, and re-arms for the next batch. It sits between the FileIO/host interface and the TaskManager.

## Interface
- `MAX_TASKS`, default 256: TaskManager task-list capacity; records beyond this are dropped.
- `CNT_W`, default 32: width of the run-cycle counter.
- `clk`  in  1  clock.
- `rst`  in  1  reset: synchronous, active-low.
- `host_valid`  in  1  host offers a record.
- `host_ready`  out  1  loader accepts a record this cycle.
- `host_data`  in  29  task record: [28] valid, [27:20] SW warp ID, [19:11] PC, [10:3] active mask, [2:0] register pairs.
- `host_last`  in  1  marks the final record of a batch.
- `Wen_FIO_TM`  out  1  task write strobe.
- `Din_FIO_TM`  out  29  task write data.
- `start_FIO_TM`  out  1  one-cycle start pulse.
- `clear_FIO_TM`  out  1  one-cycle clear pulse.
- `finished_TM_FIO`  in  1  TaskManager finished (level).
- `busy`  out  1  high in every state except LOAD.
- `done`  out  1  one-cycle pulse when a batch completes.
- `task_count`  out  9  records forwarded in the current or last batch.
- `run_cycles`  out  CNT_W  cycles spent in RUN for the last batch; saturating.
- `err_invalid`  out  1  sticky: a record with [28]=0 was dropped.
- `err_overflow`  out  1  sticky: a record beyond MAX_TASKS was dropped.

## Operation
- States: LOAD, WRLAST, START, RUN, CLEAR, HOLD.
- Reset (rst=0 at a clock edge): state goes to LOAD. All outputs are 0 except `host_ready`, which reads 1 from the first cycle after reset. `task_count`, `run_cycles` and error flags are 0. Reset mid-batch abandons the batch; no clear is issued, because the TaskManager shares the same reset.
- LOAD: `host_ready`=1. On a handshake (valid & ready):
  - If [28]=1 and `task_count` < MAX_TASKS: register Wen=1, Din=`host_data`, and increment `task_count`.
  - If [28]=0: drop the record and set `err_invalid`.
  - If [28]=1 and `task_count` = MAX_TASKS: drop the record and set `err_overflow`.
  - If this is the first handshake after `done`, first clear `task_count` and both error flags, then apply the rules above.
  - If `host_last`=1: go to WRLAST.
- WRLAST: `host_ready`=0. The final Wen (if any) is on the bus this cycle; go to START.
- START: `start_FIO_TM`=1 for exactly this cycle. Clear `run_cycles`; go to RUN.
- RUN: increment `run_cycles` each cycle, saturating at all-ones. When `finished_TM_FIO`=1 is sampled, go to CLEAR without incrementing `run_cycles` on that cycle.
- CLEAR: `clear_FIO_TM`=1 and `done`=1 for this cycle; go to HOLD.
- HOLD: one idle cycle while the TaskManager passes through its clear state, which ignores writes; go to LOAD.
- Protocol invariants:
  - `Wen_FIO_TM`, `start_FIO_TM` and `clear_FIO_TM` are mutually exclusive in every cycle, because the receiver prioritises clear over start over write.
  - Wen is never issued with Din[28]=0.
  - `finished_TM_FIO` is ignored outside RUN.
  - `host_valid` is ignored when `host_ready`=0.
- A batch of zero forwarded records (all dropped) still runs START/RUN/CLEAR; the TaskManager finishes immediately.
- `task_count` is 9 bits so that the value 256 is representable.

## Timing
- Handshake at the edge ending cycle c: Wen/Din are valid in cycle c+1. Back-to-back handshakes produce back-to-back Wen.
- Last handshake in cycle c:
  - c+1: WRLAST; the last Wen is on the bus and `host_ready`=0.
  - c+2: `start_FIO_TM`=1.
  - c+3: first RUN cycle.
- `finished_TM_FIO` sampled high in RUN cycle f:
  - f+1: `clear_FIO_TM`=1 and `done`=1.
  - f+2: HOLD.
  - f+3: `host_ready`=1.
- `run_cycles` = number of RUN cycles before the finishing cycle. It updates by cycle f+1 and holds until the next START.
- All outputs are registered except `host_ready` and `busy`, which decode the state register directly.

## Structure
- Shared package `fio_tm_pkg`: TASK_W=29, field offsets/widths (VALID_BIT, SWID, PC, AM, NREG), MAX_TASKS, and the state encoding.
- One natural sub-module: `sat_counter` (parameterised width, synchronous clear, enable, saturate at max), used for `run_cycles`.
- All other logic, including the FSM, record screening and error flags, lives in the top level.

## Test plan
- Three valid records, last on the third, with a TaskManager model finishing 10 cycles after start -> three consecutive Wen; start two cycles after the last handshake; clear and done at f+1; `task_count`=3; `run_cycles`=10.
- Records with [28]=1, 0, 1 -> two Wen; `err_invalid`=1; `task_count`=2. Start the next batch -> flags and count clear on its first handshake.
- 258 valid records -> 256 Wen; `err_overflow`=1; `task_count`=256; start still issued.
- Single record with [28]=0 and last=1 -> no Wen; start, then clear follow; `done` pulses.
- `host_valid` held high during RUN/CLEAR/HOLD -> no handshake, no Wen; `host_ready` rises at f+3. Check every cycle that Wen, start and clear are never simultaneous.
- Assert rst=0 during RUN -> next cycle: all outputs at reset values, `host_ready`=1, counters 0.
